// File: rtl/ctrl_unit.sv
// ctrl_unit: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Fetches one instruction per req/ack handshake, then spends one cycle in
// DECODE (register file / ALU settle) and one in EXECUTE (strobes fire).
//
// Optional build macro: ILLEGAL_TRAP_EN
//   defined   -> opcodes C..E halt the core and raise illegal_op until reset
//   undefined -> opcodes C..E behave as NOP, illegal_op tied low
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | post-reset bubble, moves to FETCH on the next cycle
// FETCH   | imem_req high at imem_addr=pc, waits for imem_ack, loads IR
// DECODE  | rf_addr/imm present IR[3:0] so downstream paths settle
// EXECUTE | single-cycle strobes for the decoded opcode, branch pc update
// HALT    | halted high, no requests or strobes, left only via CLB

module ctrl_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            CLB,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    input  logic [7:0]      acc_val,
    output logic [1:0]      SelAcc,
    output logic            loadAcc,
    output logic [3:0]      imm,
    output logic [3:0]      rf_addr,
    output logic            rf_we,
    output logic [2:0]      alu_op,
    output logic            halted,
    output logic            illegal_op
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDR = 4'h2;
    localparam logic [3:0] OP_STR = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_RF  = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;

    logic [3:0]      opcode;
    logic [3:0]      operand;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            trap_hit;

    assign opcode  = ir_q[7:4];
    assign operand = ir_q[3:0];

    // pc has already been incremented past the branch when EXECUTE runs,
    // so the signed offset is relative to the following instruction.
    assign branch_target = pc_q + {{(PC_W-4){operand[3]}}, operand};
    assign branch_taken  = (opcode == OP_JMP) ||
                           ((opcode == OP_JZ) && (acc_val == 8'h00));

`ifdef ILLEGAL_TRAP_EN
    logic is_reserved;
    logic illegal_q;

    assign is_reserved = (opcode == 4'hC) || (opcode == 4'hD) || (opcode == 4'hE);
    assign trap_hit    = (state_q == S_EXECUTE) && is_reserved;

    // Sticky trap flag; only reset clears it since HALT is never left otherwise.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            illegal_q <= 1'b0;
        end else if (trap_hit) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign trap_hit   = 1'b0;
    assign illegal_op = 1'b0;
`endif

    assign imem_addr = pc_q;

    // State, program counter and instruction register.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, pc and IR update; imem_ack only matters while fetching.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (opcode == OP_HLT || trap_hit) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    if (branch_taken) begin
                        pc_d = branch_target;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from state and IR; strobes exist only in EXECUTE.
    always_comb begin
        imem_req = 1'b0;
        SelAcc   = SEL_ALU;
        loadAcc  = 1'b0;
        imm      = 4'h0;
        rf_addr  = 4'h0;
        rf_we    = 1'b0;
        alu_op   = 3'd0;
        halted   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
            end
            S_DECODE: begin
                imm     = operand;
                rf_addr = operand;
            end
            S_EXECUTE: begin
                imm     = operand;
                rf_addr = operand;
                case (opcode)
                    OP_LDI: begin
                        loadAcc = 1'b1;
                        SelAcc  = SEL_IMM;
                    end
                    OP_LDR: begin
                        loadAcc = 1'b1;
                        SelAcc  = SEL_RF;
                    end
                    OP_STR: begin
                        rf_we = 1'b1;
                    end
                    OP_ADD: begin
                        loadAcc = 1'b1;
                        alu_op  = 3'd0;
                    end
                    OP_SUB: begin
                        loadAcc = 1'b1;
                        alu_op  = 3'd1;
                    end
                    OP_AND: begin
                        loadAcc = 1'b1;
                        alu_op  = 3'd2;
                    end
                    OP_OR: begin
                        loadAcc = 1'b1;
                        alu_op  = 3'd3;
                    end
                    OP_XOR: begin
                        loadAcc = 1'b1;
                        alu_op  = 3'd4;
                    end
                    OP_NOT: begin
                        loadAcc = 1'b1;
                        alu_op  = 3'd5;
                    end
                    default: begin
                        // NOP, branches, HLT and reserved opcodes strobe nothing
                        loadAcc = 1'b0;
                    end
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: directed programs in a small imem model,
// expected fetches/strobes queued by the stimulus, checked by a monitor.
`timescale 1ns/1ps

module tb_ctrl_unit;

    logic       clk = 1'b0;
    logic       CLB = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic [7:0] acc_val = 8'h00;
    logic [1:0] SelAcc;
    logic       loadAcc;
    logic [3:0] imm;
    logic [3:0] rf_addr;
    logic       rf_we;
    logic [2:0] alu_op;
    logic       halted;
    logic       illegal_op;

    ctrl_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .CLB        (CLB),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .acc_val    (acc_val),
        .SelAcc     (SelAcc),
        .loadAcc    (loadAcc),
        .imm        (imm),
        .rf_addr    (rf_addr),
        .rf_we      (rf_we),
        .alu_op     (alu_op),
        .halted     (halted),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        int         req_cycles;
    } fetch_t;

    typedef struct packed {
        logic       load;
        logic       we;
        logic [1:0] sel;
        logic [2:0] op;
        logic [3:0] imm;
        logic [3:0] rf;
    } strobe_t;

    fetch_t  exp_fetch[$];
    strobe_t exp_strobe[$];

    int tests = 0;
    int fails = 0;

    logic [7:0] prog [256];
    int         delay      = 0;
    bit         block_en   = 1'b0;
    logic [7:0] block_addr = 8'h00;
    bit         stray_en   = 1'b0;
    int         rsp_cnt    = 0;

    int cyc      = 0;
    int req_len  = 0;
    int last_ack = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_fetch(input logic [7:0] a, input int n);
        fetch_t f;
        f.addr       = a;
        f.req_cycles = n;
        exp_fetch.push_back(f);
    endtask

    task automatic push_strobe(input logic l, input logic w, input logic [1:0] sel,
                               input logic [2:0] op, input logic [3:0] opd);
        strobe_t s;
        s = {l, w, sel, op, opd, opd};
        exp_strobe.push_back(s);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    task automatic do_reset();
        CLB = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        CLB = 1'b1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " req"},     32'(imem_req),   32'h0);
        check({name, " addr"},    32'(imem_addr),  32'h0);
        check({name, " SelAcc"},  32'(SelAcc),     32'h0);
        check({name, " loadAcc"}, 32'(loadAcc),    32'h0);
        check({name, " imm"},     32'(imm),        32'h0);
        check({name, " rf_addr"}, 32'(rf_addr),    32'h0);
        check({name, " rf_we"},   32'(rf_we),      32'h0);
        check({name, " alu_op"},  32'(alu_op),     32'h0);
        check({name, " halted"},  32'(halted),     32'h0);
        check({name, " illegal"}, 32'(illegal_op), 32'h0);
    endtask

    task automatic run_to_halt(input string name, input logic exp_illegal);
        int n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, " halted"}, 32'(halted), 32'h1);
        repeat (6) @(negedge clk);
        check({name, " halted held"}, 32'(halted), 32'h1);
        check({name, " illegal_op"}, 32'(illegal_op), 32'(exp_illegal));
        check({name, " fetches outstanding"}, 32'(exp_fetch.size()), 32'h0);
        check({name, " strobes outstanding"}, 32'(exp_strobe.size()), 32'h0);
        exp_fetch.delete();
        exp_strobe.delete();
    endtask

    // Instruction memory: answers a request after `delay` waiting cycles.
    initial begin : responder
        forever begin
            @(posedge clk);
            #1;
            if (imem_req) begin
                if (block_en && imem_addr == block_addr) begin
                    imem_ack  = 1'b0;
                    imem_data = 8'h00;
                    rsp_cnt   = 0;
                end else if (rsp_cnt >= delay) begin
                    imem_ack  = 1'b1;
                    imem_data = prog[imem_addr];
                    rsp_cnt   = 0;
                end else begin
                    imem_ack  = 1'b0;
                    imem_data = 8'h00;
                    rsp_cnt++;
                end
            end else if (stray_en) begin
                imem_ack  = 1'b1;
                imem_data = 8'hFF;
                rsp_cnt   = 0;
            end else begin
                imem_ack  = 1'b0;
                imem_data = 8'h00;
                rsp_cnt   = 0;
            end
        end
    end

    // Monitor: pops expectations on fetch completions and execute strobes.
    initial begin : monitor
        fetch_t  f;
        strobe_t s_act;
        strobe_t s_exp;
        forever begin
            @(negedge clk);
            if (!CLB) begin
                req_len = 0;
            end else begin
                cyc++;
                tests++;
                if ((!loadAcc && (SelAcc != 2'b00 || alu_op != 3'd0)) ||
                    (loadAcc && rf_we) ||
                    (halted && (imem_req || loadAcc || rf_we || imm != 4'h0 || rf_addr != 4'h0)) ||
                    (imem_req && (imm != 4'h0 || rf_addr != 4'h0 || loadAcc || rf_we))) begin
                    fails++;
                    $display("FAIL invariant at cycle %0d: req=%b load=%b we=%b sel=%b op=%0d imm=%h rf=%h halted=%b",
                             cyc, imem_req, loadAcc, rf_we, SelAcc, alu_op, imm, rf_addr, halted);
                end
                if (imem_req) req_len++;
                else req_len = 0;
                if (imem_req && imem_ack) begin
                    tests++;
                    if (exp_fetch.size() == 0) begin
                        fails++;
                        $display("FAIL fetch: unexpected fetch at addr %h, none required", imem_addr);
                    end else begin
                        f = exp_fetch.pop_front();
                        if (imem_addr !== f.addr || req_len != f.req_cycles) begin
                            fails++;
                            $display("FAIL fetch: got addr %h req_cycles %0d, required addr %h req_cycles %0d",
                                     imem_addr, req_len, f.addr, f.req_cycles);
                        end
                    end
                    last_ack = cyc;
                    req_len  = 0;
                end
                if (loadAcc || rf_we) begin
                    s_act = {loadAcc, rf_we, SelAcc, alu_op, imm, rf_addr};
                    tests++;
                    if (exp_strobe.size() == 0) begin
                        fails++;
                        $display("FAIL strobe: unexpected strobe %h, none required", s_act);
                    end else begin
                        s_exp = exp_strobe.pop_front();
                        if (s_act !== s_exp || (cyc - last_ack) != 2) begin
                            fails++;
                            $display("FAIL strobe: got %h at %0d cycles after ack, required %h at 2",
                                     s_act, cyc - last_ack, s_exp);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        clear_prog();
        CLB = 1'b0;
        #12;
        check_reset_outputs("por");

        // 1: reset in the middle of a stalled fetch at address 2
        prog[2]    = 8'hF0;
        block_addr = 8'h02;
        block_en   = 1'b1;
        push_fetch(8'h00, 1);
        push_fetch(8'h01, 1);
        @(negedge clk);
        CLB = 1'b1;
        n = 0;
        while (!(imem_req && imem_addr == 8'h02) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t1 stalled at addr", 32'(imem_addr), 32'h2);
        repeat (2) @(posedge clk);
        #3 CLB = 1'b0;
        #1 check_reset_outputs("t1 mid-fetch");
        check("t1 fetches before reset", 32'(exp_fetch.size()), 32'h0);
        block_en = 1'b0;
        push_fetch(8'h00, 1);
        push_fetch(8'h01, 1);
        push_fetch(8'h02, 1);
        @(negedge clk);
        CLB = 1'b1;
        #1 check("t1 idle req", 32'(imem_req), 32'h0);
        @(posedge clk);
        #2 check("t1 req after release", 32'(imem_req), 32'h1);
        check("t1 addr after release", 32'(imem_addr), 32'h0);
        run_to_halt("t1", 1'b0);

        // 2: slow memory, LDI 5 then HLT
        clear_prog();
        prog[0] = 8'h15;
        prog[1] = 8'hF0;
        delay   = 3;
        push_fetch(8'h00, 4);
        push_strobe(1'b1, 1'b0, 2'b10, 3'd0, 4'h5);
        push_fetch(8'h01, 4);
        do_reset();
        run_to_halt("t2", 1'b0);
        delay = 0;

        // 3: LDI 3; STR 2; ADD 2; HLT
        clear_prog();
        prog[0] = 8'h13;
        prog[1] = 8'h32;
        prog[2] = 8'h42;
        prog[3] = 8'hF0;
        push_fetch(8'h00, 1);
        push_strobe(1'b1, 1'b0, 2'b10, 3'd0, 4'h3);
        push_fetch(8'h01, 1);
        push_strobe(1'b0, 1'b1, 2'b00, 3'd0, 4'h2);
        push_fetch(8'h02, 1);
        push_strobe(1'b1, 1'b0, 2'b00, 3'd0, 4'h2);
        push_fetch(8'h03, 1);
        do_reset();
        run_to_halt("t3", 1'b0);

        // 3b: remaining ALU ops, LDR and a NOP with a nonzero operand
        clear_prog();
        prog[0] = 8'h27;
        prog[1] = 8'h51;
        prog[2] = 8'h62;
        prog[3] = 8'h73;
        prog[4] = 8'h84;
        prog[5] = 8'h95;
        prog[6] = 8'h0A;
        prog[7] = 8'hF0;
        delay   = 1;
        for (int i = 0; i < 8; i++) push_fetch(8'(i), 2);
        push_strobe(1'b1, 1'b0, 2'b01, 3'd0, 4'h7);
        push_strobe(1'b1, 1'b0, 2'b00, 3'd1, 4'h1);
        push_strobe(1'b1, 1'b0, 2'b00, 3'd2, 4'h2);
        push_strobe(1'b1, 1'b0, 2'b00, 3'd3, 4'h3);
        push_strobe(1'b1, 1'b0, 2'b00, 3'd4, 4'h4);
        push_strobe(1'b1, 1'b0, 2'b00, 3'd5, 4'h5);
        do_reset();
        run_to_halt("t3b", 1'b0);
        delay = 0;

        // 4: JMP -8 from 0x02 wraps to 0xFB, then JZ +2 taken / not taken
        clear_prog();
        prog[8'h02] = 8'hA8;
        prog[8'hFB] = 8'hB2;
        prog[8'hFC] = 8'hF0;
        prog[8'hFE] = 8'hF0;
        acc_val = 8'h00;
        push_fetch(8'h00, 1);
        push_fetch(8'h01, 1);
        push_fetch(8'h02, 1);
        push_fetch(8'hFB, 1);
        push_fetch(8'hFE, 1);
        do_reset();
        run_to_halt("t4 jz taken", 1'b0);
        acc_val = 8'h01;
        push_fetch(8'h00, 1);
        push_fetch(8'h01, 1);
        push_fetch(8'h02, 1);
        push_fetch(8'hFB, 1);
        push_fetch(8'hFC, 1);
        do_reset();
        run_to_halt("t4 jz not taken", 1'b0);
        acc_val = 8'h00;

        // 5: reserved opcodes
        clear_prog();
        prog[0] = 8'hC0;
        prog[1] = 8'hE5;
        prog[2] = 8'h15;
        prog[3] = 8'hF0;
        push_fetch(8'h00, 1);
`ifdef ILLEGAL_TRAP_EN
        do_reset();
        run_to_halt("t5 trap", 1'b1);
`else
        push_fetch(8'h01, 1);
        push_fetch(8'h02, 1);
        push_strobe(1'b1, 1'b0, 2'b10, 3'd0, 4'h5);
        push_fetch(8'h03, 1);
        do_reset();
        run_to_halt("t5 nop", 1'b0);
`endif

        // 6: stray acks outside FETCH must not touch IR or pc
        clear_prog();
        prog[0]  = 8'h17;
        prog[1]  = 8'h38;
        prog[2]  = 8'hF0;
        stray_en = 1'b1;
        push_fetch(8'h00, 1);
        push_strobe(1'b1, 1'b0, 2'b10, 3'd0, 4'h7);
        push_fetch(8'h01, 1);
        push_strobe(1'b0, 1'b1, 2'b00, 3'd0, 4'h8);
        push_fetch(8'h02, 1);
        do_reset();
        run_to_halt("t6", 1'b0);
        stray_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
